rst_seq: RTL and testbench
==========================

# rst_seq

Parametrised reset sequencer and run watchdog for the processor top level. It synchronises one asynchronous active-low reset into `N_CH` per-domain reset outputs and releases them in staggered order after a hold period. It then counts run cycles and re-asserts every reset on an error pulse or on a watchdog expiry. It is the synthesizable successor to the bench clock/reset generator: the error stop, cycle limit and reset length now live in hardware and are parametrised.

## Interface
Parameters:
- `N_CH`, default 4: number of reset output channels (1..16).
- `SYNC_STAGES`, default 2: depth of the reset synchroniser (2..4).
- `HOLD_CYCLES`, default 4: cycles all resets stay asserted after synchronisation (≥1).
- `STAGGER`, default 2: cycles between successive channel releases (≥1).
- `CNT_W`, default 32: width of `cycle_count` and the watchdog counter.
- `WDOG_LIMIT`, default 100: number of consecutive RUN cycles without `kick` that trips the watchdog (≥2, < 2^CNT_W).

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `err`, input, 1: error pulse from the core; sampled only in RUN.
- `kick`, input, 1: watchdog service pulse; sampled only in RUN.
- `rst_out`, output, N_CH: per-channel resets, active-high; asserted asynchronously, released synchronously.
- `rst_done`, output, 1: high while in RUN.
- `err_flag`, output, 1: sticky, set on entry to FAULT.
- `timeout`, output, 1: sticky, set on entry to TIMEOUT.
- `cycle_count`, output, CNT_W: number of RUN cycles elapsed; saturates at all-ones.

## Operation
- States: SYNC, HOLD, RELEASE, RUN, FAULT, TIMEOUT.
- While `rst`=0, from any state, asynchronously:
  - state=SYNC, `rst_out`=all ones;
  - `rst_done`=0, `err_flag`=0, `timeout`=0;
  - `cycle_count`=0, watchdog count=0, synchroniser=0.
- SYNC: a chain of `SYNC_STAGES` flops shifts in 1. The transition to HOLD occurs on the edge where the last stage already holds 1.
- HOLD: the hold counter counts `HOLD_CYCLES` edges in HOLD. The final edge moves to RELEASE and clears `rst_out[0]` on that same edge.
- RELEASE: `rst_out[k]` clears `STAGGER` edges after `rst_out[k-1]`. The edge that clears `rst_out[N_CH-1]` also enters RUN. With `N_CH`=1, HOLD goes directly to RUN.
- RUN:
  - `cycle_count` increments every edge and saturates.
  - The watchdog count increments every edge and clears on an edge where `kick`=1.
  - If the count equals `WDOG_LIMIT-1` and `kick`=0, the edge enters TIMEOUT.
- FAULT: entered on an edge in RUN with `err`=1. Sets `rst_out`=all ones and `err_flag`=1. Terminal until `rst` is asserted.
- TIMEOUT: sets `rst_out`=all ones and `timeout`=1. Terminal until `rst` is asserted.
- Simultaneous events:
  - `err` together with watchdog expiry goes to FAULT (`timeout` stays 0).
  - `kick` together with the expiry threshold clears the count; no timeout.
- `err` and `kick` are ignored outside RUN. `cycle_count` freezes in FAULT and TIMEOUT.

## Timing
- Edge 1 is the first rising `clk` edge after `rst` rises:
  - `rst_out[k]` falls at edge SYNC_STAGES+1+HOLD_CYCLES+k·STAGGER;
  - `rst_done` rises at the edge that releases the last channel.
- Defaults: channels release at edges 7/9/11/13 and `rst_done` rises at edge 13.
- Re-assertion of `rst_out` in FAULT or TIMEOUT is registered, i.e. visible one edge after the triggering sample.
- `rst` falling mid-sequence, or in RUN/FAULT/TIMEOUT, asserts all outputs to their reset values with no clock needed. A short `rst` glitch restarts the full sequence.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `RST_SEQ_WDOG_EN` defined: the watchdog counter, `kick` handling and the TIMEOUT state are built as described.
- Macro undefined:
  - the watchdog counter and TIMEOUT are removed;
  - `kick` is ignored and `timeout` is tied to 0;
  - RUN leaves only on `err`;
  - `cycle_count` still counts and saturates.

## Test plan
- Defaults, release `rst` → `rst_out` goes 1111 → 1110@7 → 1100@9 → 1000@11 → 0000@13; `rst_done`=1 from edge 13.
- RUN with `kick`=0 (WDOG_EN) → TIMEOUT at the 100th RUN edge; `timeout`=1, `rst_out`=1111, `cycle_count`=100 frozen.
- `kick` every 50 cycles for 1000 cycles → no timeout; `cycle_count`=1000. Then `kick` exactly on the threshold cycle → still no timeout.
- `err` pulse at RUN cycle 20 → FAULT, `err_flag`=1, `rst_out`=1111, `cycle_count`=20. `err` during RELEASE → ignored.
- `err` on the expiry edge → FAULT, `err_flag`=1, `timeout`=0.
- `rst` low for 10 time units mid-RELEASE and mid-TIMEOUT → immediate all-ones / flags cleared, and the full sequence repeats with identical edge numbers.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: reset synchroniser, staggered per-domain reset release and run watchdog
//   clk         - single clock
//   rst         - asynchronous active-low reset input
//   err         - error pulse, sampled only in RUN
//   kick        - watchdog service pulse, sampled only in RUN
//   rst_out     - per-channel active-high resets, asserted async, released sync
//   rst_done    - high while in RUN
//   err_flag    - sticky, set on entry to FAULT
//   timeout     - sticky, set on entry to TIMEOUT (tied low without the watchdog)
//   cycle_count - RUN cycles elapsed, saturating
//   RST_SEQ_WDOG_EN - define to build the watchdog counter and TIMEOUT state
module rst_seq #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 32,
    parameter int WDOG_LIMIT  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err,
    input  logic             kick,
    output logic [N_CH-1:0]  rst_out,
    output logic             rst_done,
    output logic             err_flag,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int CMAX = HOLD_CYCLES > STAGGER ? HOLD_CYCLES : STAGGER;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [2:0] {SYNC, HOLD, RELEASE, RUN, FAULT, TIMEOUT} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [N_CH-1:0]        nxt_out;
    logic                   last;
    // channels release lowest first, so each release is a left shift of the mask
    assign nxt_out = rst_out << 1;
    assign last    = ~|nxt_out;
`ifdef RST_SEQ_WDOG_EN
    logic [CNT_W-1:0] wd;
    logic             expire;
    assign expire = wd == CNT_W'(WDOG_LIMIT - 1) && !kick;
`else
    logic unused_kick;
    assign unused_kick = kick;
    assign timeout     = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            sync        <= '0;
            cnt         <= '0;
            rst_out     <= '1;
            rst_done    <= 1'b0;
            err_flag    <= 1'b0;
            cycle_count <= '0;
`ifdef RST_SEQ_WDOG_EN
            wd          <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
            case (state)
                SYNC: if (sync[SYNC_STAGES-1]) state <= HOLD;
                HOLD, RELEASE: begin
                    if (cnt == (state == HOLD ? CW'(HOLD_CYCLES - 1) : CW'(STAGGER - 1))) begin
                        cnt      <= '0;
                        rst_out  <= nxt_out;
                        rst_done <= last;
                        state    <= last ? RUN : RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (~&cycle_count) cycle_count <= cycle_count + CNT_W'(1);
                    if (err) begin
                        state    <= FAULT;
                        rst_out  <= '1;
                        rst_done <= 1'b0;
                        err_flag <= 1'b1;
                    end
`ifdef RST_SEQ_WDOG_EN
                    else if (expire) begin
                        state    <= TIMEOUT;
                        rst_out  <= '1;
                        rst_done <= 1'b0;
                        timeout  <= 1'b1;
                    end
                    wd <= kick ? '0 : wd + CNT_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: randomized self-checking bench for rst_seq against an edge-count model
module tb_rst_seq;
    localparam int N_CH = 4, SYNC_STAGES = 2, HOLD_CYCLES = 4, STAGGER = 2, CNT_W = 32, WDOG_LIMIT = 100;
    localparam int LR = SYNC_STAGES + 1 + HOLD_CYCLES + (N_CH - 1) * STAGGER;
    localparam longint MAXC = (longint'(1) << CNT_W) - 1;
`ifdef RST_SEQ_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, err = 1'b0, kick = 1'b0;
    logic [N_CH-1:0] rst_out;
    logic rst_done, err_flag, timeout;
    logic [CNT_W-1:0] cycle_count;
    int n_cmp = 0, n_bad = 0;
    // model: edges since release, phase 0=sequencing 1=run 2=fault 3=timeout
    int en = 0, ph = 0;
    longint mc = 0, mw = 0;

    rst_seq #(.N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES),
              .STAGGER(STAGGER), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) dut (
        .clk(clk), .rst(rst), .err(err), .kick(kick), .rst_out(rst_out),
        .rst_done(rst_done), .err_flag(err_flag), .timeout(timeout), .cycle_count(cycle_count));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH-1:0] exp_out();
        logic [N_CH-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k] = (ph >= 2) || (en < SYNC_STAGES + 1 + HOLD_CYCLES + k * STAGGER);
        return v;
    endfunction

    task automatic cmp_all();
        check("rst_out", 64'(rst_out), 64'(exp_out()));
        check("rst_done", 64'(rst_done), 64'(ph == 1));
        check("err_flag", 64'(err_flag), 64'(ph == 2));
        check("timeout", 64'(timeout), 64'(ph == 3));
        check("cycle_count", 64'(cycle_count), 64'(mc));
    endtask

    task automatic step(input logic e, input logic k);
        err  = e;
        kick = k;
        @(posedge clk);
        en++;
        if (ph == 0 && en == LR) ph = 1;
        else if (ph == 1) begin
            if (mc < MAXC) mc++;
            if (e) ph = 2;
            else if (WD && mw == WDOG_LIMIT - 1 && !k) ph = 3;
            mw = k ? 0 : mw + 1;
        end
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 0; ph = 0; mc = 0; mw = 0;
        #2;
        cmp_all();
        #8;
        rst = 1'b1;
    endtask

    task automatic sequence_in();
        for (int i = 0; i < LR; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("run_entry_done", 64'(rst_done), 64'd1);
        check("run_entry_out", 64'(rst_out), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        sequence_in();
        for (int i = 0; i < 150; i++) step(1'b0, 1'b0);
        if (WD) begin
            check("wdog_timeout", 64'(timeout), 64'd1);
            check("wdog_count", 64'(cycle_count), 64'd100);
        end else check("free_count", 64'(cycle_count), 64'd150);
        do_reset();
        for (int i = 0; i < 9; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset();
        sequence_in();
        for (int i = 0; i < 1000; i++) step(1'b0, i % 50 == 49);
        check("kick_count", 64'(cycle_count), 64'd1000);
        check("kick_no_timeout", 64'(timeout), 64'd0);
        for (int i = 0; i < WDOG_LIMIT - 1; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        check("threshold_kick", 64'(timeout), 64'd0);
        for (int i = 0; i < 300 && ph == 1; i++) step($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset();
        sequence_in();
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("fault_count", 64'(cycle_count), 64'd20);
        check("fault_flag", 64'(err_flag), 64'd1);
        check("fault_out", 64'(rst_out), 64'hF);
        do_reset();
        for (int i = 0; i < LR; i++) step(1'b0, 1'b0);
        for (int i = 0; i < WDOG_LIMIT - 1; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("expiry_err_flag", 64'(err_flag), 64'd1);
        check("expiry_err_timeout", 64'(timeout), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
